// File: rtl/memory_stage.sv
// Y86-64 memory-access stage: decodes an execute result into one data-memory
// access, waits out the memory's registered read latency, and hands a write-back bundle on.
module memory_stage #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [2:0]  in_stat,
    input  logic [63:0] in_valE,
    input  logic [63:0] in_valA,
    input  logic [63:0] in_valP,
    input  logic [3:0]  in_dstE,
    input  logic [3:0]  in_dstM,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [2:0]  out_stat,
    output logic [63:0] out_valE,
    output logic [63:0] out_valM,
    output logic [3:0]  out_dstE,
    output logic [3:0]  out_dstM
);

    // state   | meaning
    // IDLE    | waiting for an execute result
    // ISSUE   | one-cycle memory strobe
    // CAPTURE | read data arrives from the registered memory
    // OUTPUT  | write-back bundle held until out_ready
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUTPUT} state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    state_t      state_q, state_d;
    logic [3:0]  icode_q, dst_e_q, dst_m_q;
    logic [2:0]  stat_q;
    logic [63:0] val_e_q, val_m_q, addr_q, wdata_q;
    logic        write_q;

    logic        is_wr, is_rd, need_access, addr_bad, go;
    logic [63:0] acc_addr, acc_data;
    logic [2:0]  stat_new;

    always_comb begin
        is_wr    = 1'b0;
        is_rd    = 1'b0;
        acc_addr = in_valE;
        acc_data = in_valA;
        case (in_icode)
            4'h4, 4'hA: is_wr = 1'b1;
            4'h8: begin
                is_wr    = 1'b1;
                acc_data = in_valP;
            end
            4'h5: is_rd = 1'b1;
            4'h9, 4'hB: begin
                is_rd    = 1'b1;
                acc_addr = in_valA;
            end
            default: ;
        endcase
        need_access = (is_wr || is_rd) && (in_stat == STAT_AOK);
        addr_bad    = acc_addr >= 64'(MEM_WORDS);
        go          = need_access && !addr_bad;
        stat_new    = (need_access && addr_bad) ? STAT_ADR : in_stat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = go ? ISSUE : OUTPUT;
            ISSUE:   state_d = write_q ? OUTPUT : CAPTURE;
            CAPTURE: state_d = OUTPUT;
            OUTPUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_q <= '0;
            stat_q  <= '0;
            val_e_q <= '0;
            val_m_q <= '0;
            dst_e_q <= '0;
            dst_m_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            icode_q <= in_icode;
            stat_q  <= stat_new;
            val_e_q <= in_valE;
            val_m_q <= '0;
            dst_e_q <= in_dstE;
            dst_m_q <= in_dstM;
            addr_q  <= go ? acc_addr : '0;
            wdata_q <= (go && is_wr) ? acc_data : '0;
            write_q <= go && is_wr;
        end else if (state_q == CAPTURE) begin
            val_m_q <= mem_read_data;
        end
    end

    // Strobes decode from state only, so an async reset kills them in the same cycle.
    always_comb begin
        in_ready       = rst_n && (state_q == IDLE);
        out_valid      = (state_q == OUTPUT);
        mem_write      = (state_q == ISSUE) && write_q;
        mem_read       = (state_q == ISSUE) && !write_q;
        mem_address    = (state_q == ISSUE) ? addr_q : '0;
        mem_write_data = mem_write ? wdata_q : '0;
    end

    assign out_icode = icode_q;
    assign out_stat  = stat_q;
    assign out_valE  = val_e_q;
    assign out_valM  = val_m_q;
    assign out_dstE  = dst_e_q;
    assign out_dstM  = dst_m_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed Y86 memory scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_icode = '0;
    logic [2:0]  in_stat = '0;
    logic [63:0] in_valE = '0, in_valA = '0, in_valP = '0;
    logic [3:0]  in_dstE = '0, in_dstM = '0;
    logic [63:0] mem_address, mem_write_data;
    logic        mem_write, mem_read;
    logic [63:0] mem_read_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_icode, out_dstE, out_dstM;
    logic [2:0]  out_stat;
    logic [63:0] out_valE, out_valM;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt = 0, rd_cnt = 0;
    logic [63:0] last_addr = '0, last_wdata = '0;

    logic [63:0] phys_mem [256];
    logic [63:0] ref_mem  [256];

    memory_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_stat(in_stat),
        .in_valE(in_valE), .in_valA(in_valA), .in_valP(in_valP),
        .in_dstE(in_dstE), .in_dstM(in_dstM),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_stat(out_stat),
        .out_valE(out_valE), .out_valM(out_valM),
        .out_dstE(out_dstE), .out_dstM(out_dstM)
    );

    always #5 clk = ~clk;

    // Data memory with a one-cycle registered read port.
    always @(posedge clk) begin
        if (mem_write && mem_address < 64'd256) phys_mem[mem_address[7:0]] <= mem_write_data;
        if (mem_read)
            mem_read_data <= (mem_address < 64'd256) ? phys_mem[mem_address[7:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(negedge clk) begin
        if (mem_write) begin
            wr_cnt++;
            last_addr  = mem_address;
            last_wdata = mem_write_data;
        end
        if (mem_read) begin
            rd_cnt++;
            last_addr = mem_address;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] icode, input logic [2:0] stat,
                             input logic [63:0] ve, input logic [63:0] vm,
                             input logic [3:0] de, input logic [3:0] dm);
        check({tag, ".icode"}, 64'(out_icode), 64'(icode));
        check({tag, ".stat"},  64'(out_stat),  64'(stat));
        check({tag, ".valE"},  out_valE, ve);
        check({tag, ".valM"},  out_valM, vm);
        check({tag, ".dstE"},  64'(out_dstE), 64'(de));
        check({tag, ".dstM"},  64'(out_dstM), 64'(dm));
    endtask

    // One full transaction: model predicts the result, DUT is driven and compared.
    task automatic run(input string tag, input logic [3:0] icode, input logic [2:0] stat,
                       input logic [63:0] ve, input logic [63:0] va, input logic [63:0] vp,
                       input logic [3:0] de, input logic [3:0] dm, input int hold);
        bit          wr, rd, acc;
        logic [63:0] addr, wdata, exp_m;
        logic [2:0]  exp_stat;
        int          exp_lat, lat, wr0, rd0;

        wr    = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
        rd    = (icode == 4'h5) || (icode == 4'hB) || (icode == 4'h9);
        addr  = (icode == 4'hB || icode == 4'h9) ? va : ve;
        wdata = (icode == 4'h8) ? vp : va;
        exp_stat = stat;
        acc = (wr || rd) && stat == 3'd1;
        if (acc && addr >= 64'd256) begin
            acc = 1'b0;
            exp_stat = 3'd3;
        end
        exp_m = 64'd0;
        if (acc && rd) exp_m = ref_mem[addr[7:0]];
        if (acc && wr) ref_mem[addr[7:0]] = wdata;
        exp_lat = !acc ? 1 : (wr ? 2 : 3);

        wr0 = wr_cnt;
        rd0 = rd_cnt;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_icode = icode; in_stat = stat; in_valE = ve; in_valA = va; in_valP = vp;
        in_dstE = de; in_dstM = dm; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_valE = 64'($urandom); in_valA = 64'($urandom);
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_out(tag, icode, exp_stat, ve, exp_m, de, dm);
        check({tag, ".writes"}, 64'(wr_cnt - wr0), (acc && wr) ? 64'd1 : 64'd0);
        check({tag, ".reads"},  64'(rd_cnt - rd0), (acc && rd) ? 64'd1 : 64'd0);
        if (acc) check({tag, ".addr"}, last_addr, addr);
        if (acc && wr) check({tag, ".wdata"}, last_wdata, wdata);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".hold_strobe"}, 64'({mem_read, mem_write}), 64'd0);
            check_out({tag, ".hold"}, icode, exp_stat, ve, exp_m, de, dm);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".retired"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ra;
        logic [3:0]  ic;
        logic [2:0]  st;

        for (int i = 0; i < 256; i++) begin
            phys_mem[i] = 64'd0;
            ref_mem[i]  = 64'd0;
        end

        #2;
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.strobes", 64'({mem_read, mem_write}), 64'd0);
        check("rst.mem_address", mem_address, 64'd0);
        check_out("rst", 4'd0, 3'd0, 64'd0, 64'd0, 4'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("rmmovq",   4'h4, 3'd1, 64'h10, 64'hDEADBEEF, 64'h0, 4'hF, 4'hF, 0);
        run("mrmovq",   4'h5, 3'd1, 64'h10, 64'h0, 64'h0, 4'hF, 4'h2, 0);
        run("call",     4'h8, 3'd1, 64'hF8, 64'h0, 64'h123, 4'h4, 4'hF, 0);
        run("ret",      4'h9, 3'd1, 64'h100, 64'hF8, 64'h0, 4'h4, 4'hF, 0);
        run("rd_top",   4'h5, 3'd1, 64'hFF, 64'h0, 64'h0, 4'hF, 4'h1, 0);
        run("rd_adr",   4'h5, 3'd1, 64'h100, 64'h0, 64'h0, 4'hF, 4'h1, 0);
        run("push_adr", 4'hA, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55, 64'h0, 4'h4, 4'hF, 0);
        run("push_top", 4'hA, 3'd1, 64'hFF, 64'h77, 64'h0, 4'h4, 4'hF, 0);
        run("pop_top",  4'hB, 3'd1, 64'h100, 64'hFF, 64'h0, 4'h4, 4'h3, 0);
        run("opq",      4'h6, 3'd1, 64'h1234, 64'h9, 64'h0, 4'h3, 4'hF, 0);
        run("ins_wr",   4'h4, 3'd4, 64'h20, 64'h99, 64'h0, 4'hF, 4'hF, 0);
        run("hlt_adr",  4'h5, 3'd2, 64'h300, 64'h0, 64'h0, 4'hF, 4'h1, 0);
        run("bp_read",  4'h5, 3'd1, 64'h10, 64'h0, 64'h0, 4'hF, 4'h5, 5);

        // Reset in the middle of a read strobe.
        @(negedge clk);
        in_icode = 4'h5; in_stat = 3'd1; in_valE = 64'h10; in_dstE = 4'hF; in_dstM = 4'h1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rstmid.read_on", 64'(mem_read), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.read_off", 64'(mem_read), 64'd0);
        check("rstmid.out_valid", 64'(out_valid), 64'd0);
        check("rstmid.in_ready", 64'(in_ready), 64'd0);
        check("rstmid.mem_address", mem_address, 64'd0);
        check_out("rstmid", 4'd0, 3'd0, 64'd0, 64'd0, 4'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid.in_ready_after", 64'(in_ready), 64'd1);
        run("post_rst", 4'h5, 3'd1, 64'h10, 64'h0, 64'h0, 4'hF, 4'h1, 0);

        for (int n = 0; n < 60; n++) begin
            ic = 4'($urandom_range(0, 11));
            st = ($urandom_range(0, 9) < 8) ? 3'd1 : 3'($urandom_range(2, 4));
            case ($urandom_range(0, 3))
                0: ra = 64'd256 + 64'($urandom_range(0, 3)) - 64'd2;
                1: ra = {32'($urandom), 32'($urandom)};
                default: ra = 64'($urandom_range(0, 255));
            endcase
            run("rand", ic, st, ra, ($urandom_range(0, 1) != 0) ? ra : 64'($urandom_range(0, 300)),
                64'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
